video_tpg: RTL

- Free-running video timing generator plus test-pattern source.
- Produces 24-bit RGB, hsync, vsync and data-enable for the R/G/B TMDS encoders in place of the clocked-video output, so the HDMI path can be brought up without the Nios/DRAM system.
- Runs in the pixel-clock domain (the serializer core clock).
- All outputs are registered and mutually aligned.

---
 rtl/video_tpg_if.sv | 22 ++
 rtl/video_tpg.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/video_tpg_if.sv
// Video stream bundle from the test-pattern generator to the TMDS encoders.
//   vdata       : 24-bit pixel {R[23:16], G[15:8], B[7:0]}
//   hsync/vsync : sync strobes, polarity set by the generator parameters
//   de          : active-video enable (encoder VDE)
//   frame_start : one-cycle pulse with the first active pixel of a frame
//   frame_cnt   : completed-frame counter, aligned with the other signals
interface video_tpg_if;
  logic [23:0] vdata;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        frame_start;
  logic [7:0]  frame_cnt;

  modport master (
    output vdata, hsync, vsync, de, frame_start, frame_cnt
  );

  modport slave (
    input vdata, hsync, vsync, de, frame_start, frame_cnt
  );
endinterface

// File: rtl/video_tpg.sv
// Free-running video timing generator with a built-in test-pattern source.
// Runs in the pixel-clock domain and replaces the clocked-video output so the
// HDMI path can be brought up stand-alone. All outputs are registered and
// mutually aligned, one cycle behind the counter state they describe.
//   CLK         : pixel clock
//   RSTn        : asynchronous active-low reset
//   en          : generator enable (registered once before use)
//   pattern_sel : 0 bars, 1 scrolling grey ramp, 2 checkerboard, 3 solid
//   solid_rgb   : colour for the solid pattern
//   vid         : video stream (master side of video_tpg_if)
module video_tpg #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               en,
  input  logic [1:0]         pattern_sel,
  input  logic [23:0]        solid_rgb,
  video_tpg_if.master        vid
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned BAR_W   = H_ACTIVE / 8;
  // Grey ramp reads h_cnt[7:0] and the checkerboard reads v_cnt[5].
  localparam int unsigned HW = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
  localparam int unsigned VW = ($clog2(V_TOTAL) > 6) ? $clog2(V_TOTAL) : 6;

  logic          en_q;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [HW-1:0] bar_px;
  logic [2:0]    bar_idx;
  logic [7:0]    frame_cnt_q;
  logic [1:0]    pat_q;
  logic [23:0]   rgb_q;

  logic [23:0]   vdata_q;
  logic          hsync_q, vsync_q, de_q, fs_q;
  logic [7:0]    fcnt_out_q;

  logic          h_last, v_last, frame_origin;
  logic [1:0]    pat_cur;
  logic [23:0]   rgb_cur, bar_rgb, pix;
  logic [7:0]    grey;
  logic          de_d, hs_act, vs_act;

  assign h_last       = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last       = (v_cnt == VW'(V_TOTAL - 1));
  assign frame_origin = (h_cnt == '0) && (v_cnt == '0);

  // The frame's first pixel already uses the freshly sampled controls.
  assign pat_cur = frame_origin ? pattern_sel : pat_q;
  assign rgb_cur = frame_origin ? solid_rgb   : rgb_q;

  always_comb begin
    bar_rgb = 24'h000000;
    unique case (bar_idx)
      3'd0: bar_rgb = 24'hFFFFFF;
      3'd1: bar_rgb = 24'hFFFF00;
      3'd2: bar_rgb = 24'h00FFFF;
      3'd3: bar_rgb = 24'h00FF00;
      3'd4: bar_rgb = 24'hFF00FF;
      3'd5: bar_rgb = 24'hFF0000;
      3'd6: bar_rgb = 24'h0000FF;
      3'd7: bar_rgb = 24'h000000;
    endcase

    grey = h_cnt[7:0] + frame_cnt_q;

    pix = 24'h000000;
    unique case (pat_cur)
      2'd0: pix = bar_rgb;
      2'd1: pix = {grey, grey, grey};
      2'd2: pix = (h_cnt[5] ^ v_cnt[5]) ? 24'hFFFFFF : 24'h000000;
      2'd3: pix = rgb_cur;
    endcase

    de_d   = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    hs_act = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
    vs_act = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      en_q        <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      bar_px      <= '0;
      bar_idx     <= 3'd0;
      frame_cnt_q <= 8'd0;
      pat_q       <= 2'd0;
      rgb_q       <= 24'h000000;
      vdata_q     <= 24'h000000;
      hsync_q     <= ~HS_POL;
      vsync_q     <= ~VS_POL;
      de_q        <= 1'b0;
      fs_q        <= 1'b0;
      fcnt_out_q  <= 8'd0;
    end else begin
      en_q       <= en;
      fcnt_out_q <= frame_cnt_q;
      if (!en_q) begin
        // Disabled: park at the frame origin; frame_cnt keeps its value.
        h_cnt   <= '0;
        v_cnt   <= '0;
        bar_px  <= '0;
        bar_idx <= 3'd0;
        vdata_q <= 24'h000000;
        hsync_q <= ~HS_POL;
        vsync_q <= ~VS_POL;
        de_q    <= 1'b0;
        fs_q    <= 1'b0;
      end else begin
        vdata_q <= de_d ? pix : 24'h000000;
        hsync_q <= hs_act ? HS_POL : ~HS_POL;
        vsync_q <= vs_act ? VS_POL : ~VS_POL;
        de_q    <= de_d;
        fs_q    <= frame_origin;

        if (frame_origin) begin
          pat_q <= pattern_sel;
          rgb_q <= solid_rgb;
        end

        if (h_last) begin
          h_cnt   <= '0;
          bar_px  <= '0;
          bar_idx <= 3'd0;
          if (v_last) begin
            v_cnt       <= '0;
            frame_cnt_q <= frame_cnt_q + 8'd1;
          end else begin
            v_cnt <= v_cnt + 1'b1;
          end
        end else begin
          h_cnt <= h_cnt + 1'b1;
          // Last bar index saturates so remainder pixels extend bar 7.
          if (bar_idx != 3'd7) begin
            if (bar_px == HW'(BAR_W - 1)) begin
              bar_px  <= '0;
              bar_idx <= bar_idx + 3'd1;
            end else begin
              bar_px <= bar_px + 1'b1;
            end
          end
        end
      end
    end
  end

  assign vid.vdata       = vdata_q;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.de          = de_q;
  assign vid.frame_start = fs_q;
  assign vid.frame_cnt   = fcnt_out_q;

endmodule
